biriscv_mul_issue_ctrl: RTL and testbench

- Issue-side controller for the iterative low-word multiplier: the requester end of its opcode/writeback interface.
- Accepts a decoded M-extension instruction from the issue stage and sends one opcode_valid pulse with latched operands.
- Holds a busy/hazard scoreboard entry for rd until the result returns, then writes the result to the register file.
- Handles pipeline flush, rd-mismatch checking and a watchdog timeout.

---
 rtl/biriscv_mul_issue_ctrl_pkg.sv | 40 ++++
 rtl/biriscv_mul_watchdog.sv | 30 +++
 rtl/biriscv_mul_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_biriscv_mul_issue_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_mul_issue_ctrl_pkg.sv
// Shared RV32M decode constants, FSM encodings and decode helpers for the
// multiplier issue controller.
package biriscv_mul_issue_ctrl_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_DISPATCH_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC     = 2'd2;
  localparam logic [1:0] ST_DRAIN_ENC    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_DISPATCH = ST_DISPATCH_ENC,
    ST_WAIT     = ST_WAIT_ENC,
    ST_DRAIN    = ST_DRAIN_ENC
  } state_t;

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
  endfunction

  function automatic logic is_mul(input logic [31:0] insn);
    return is_muldiv(insn) && (insn[14:12] == F3_MUL);
  endfunction

  // High-word variants share the encoding space but this multiplier only
  // produces the low word.
  function automatic logic is_mul_unsupported(input logic [31:0] insn);
    return is_muldiv(insn) &&
           ((insn[14:12] == F3_MULH) || (insn[14:12] == F3_MULHSU) ||
            (insn[14:12] == F3_MULHU));
  endfunction

endpackage

// File: rtl/biriscv_mul_watchdog.sv
// Cycle counter for the multiplier wait window; flags the last allowed cycle.
// Latency: combinational timeout flag; no backpressure.
module biriscv_mul_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th counted cycle, so the abort lands
  // after exactly that many cycles without a writeback.
  assign timeout_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/biriscv_mul_issue_ctrl.sv
// Issue-side requester for the iterative multiplier: dispatches one MUL, tracks rd, writes back.
// Latency: dispatch 1 cycle after accept, rf write 1 cycle after wb; accept stalls while busy.
module biriscv_mul_issue_ctrl
  import biriscv_mul_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [4:0]  issue_ra_idx_i,
  input  logic [4:0]  issue_rb_idx_i,
  input  logic [31:0] issue_ra_operand_i,
  input  logic [31:0] issue_rb_operand_i,
  output logic        issue_accept_o,
  output logic        illegal_o,
  output logic        busy_o,
  output logic        pending_valid_o,
  output logic [4:0]  pending_rd_o,
  input  logic        flush_i,
  output logic        mul_opcode_valid_o,
  output logic [31:0] mul_opcode_opcode_o,
  output logic [31:0] mul_opcode_pc_o,
  output logic [4:0]  mul_opcode_rd_idx_o,
  output logic [4:0]  mul_opcode_ra_idx_o,
  output logic [4:0]  mul_opcode_rb_idx_o,
  output logic [31:0] mul_opcode_ra_operand_o,
  output logic [31:0] mul_opcode_rb_operand_o,
  input  logic        mul_wb_valid_i,
  input  logic [31:0] mul_wb_value_i,
  input  logic [4:0]  mul_wb_rd_idx_i,
  output logic        rf_wr_en_o,
  output logic [4:0]  rf_wr_idx_o,
  output logic [31:0] rf_wr_data_o,
  output logic        error_o
);

  state_t state_q, state_d;
  logic   idle, do_accept, do_illegal, wb_match, timeout;
  logic   wr_fire, err_fire, pend_clr;

  assign idle       = (state_q == ST_IDLE);
  assign do_accept  = issue_valid_i && idle && is_mul(issue_opcode_i) && !flush_i;
  assign do_illegal = issue_valid_i && idle && is_mul_unsupported(issue_opcode_i) && !flush_i;
  assign wb_match   = (mul_wb_rd_idx_i == mul_opcode_rd_idx_o);

  assign issue_accept_o     = do_accept;
  assign busy_o             = !idle;
  assign mul_opcode_valid_o = (state_q == ST_DISPATCH);

  biriscv_mul_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q == ST_DISPATCH),
    .count_i  ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_fire  = 1'b0;
    err_fire = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (do_accept) state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (flush_i) begin
          state_d  = ST_DRAIN;
          pend_clr = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A returning result beats a same-cycle flush: it has already retired.
        if (mul_wb_valid_i) begin
          state_d  = ST_IDLE;
          pend_clr = 1'b1;
          wr_fire  = wb_match;
          err_fire = !wb_match;
        end else if (timeout) begin
          state_d  = ST_IDLE;
          pend_clr = 1'b1;
          err_fire = 1'b1;
        end else if (flush_i) begin
          state_d  = ST_DRAIN;
          pend_clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mul_wb_valid_i) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d  = ST_IDLE;
          err_fire = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_o               <= 1'b0;
      error_o                 <= 1'b0;
      rf_wr_en_o              <= 1'b0;
      rf_wr_idx_o             <= '0;
      rf_wr_data_o            <= '0;
      pending_valid_o         <= 1'b0;
      pending_rd_o            <= '0;
      mul_opcode_opcode_o     <= '0;
      mul_opcode_pc_o         <= '0;
      mul_opcode_rd_idx_o     <= '0;
      mul_opcode_ra_idx_o     <= '0;
      mul_opcode_rb_idx_o     <= '0;
      mul_opcode_ra_operand_o <= '0;
      mul_opcode_rb_operand_o <= '0;
    end else begin
      illegal_o  <= do_illegal;
      error_o    <= err_fire;
      rf_wr_en_o <= wr_fire && (mul_opcode_rd_idx_o != 5'd0);
      if (wr_fire) begin
        rf_wr_idx_o  <= mul_wb_rd_idx_i;
        rf_wr_data_o <= mul_wb_value_i;
      end
      if (do_accept) begin
        pending_valid_o         <= 1'b1;
        pending_rd_o            <= issue_rd_idx_i;
        mul_opcode_opcode_o     <= issue_opcode_i;
        mul_opcode_pc_o         <= issue_pc_i;
        mul_opcode_rd_idx_o     <= issue_rd_idx_i;
        mul_opcode_ra_idx_o     <= issue_ra_idx_i;
        mul_opcode_rb_idx_o     <= issue_rb_idx_i;
        mul_opcode_ra_operand_o <= issue_ra_operand_i;
        mul_opcode_rb_operand_o <= issue_rb_operand_i;
      end else if (pend_clr) begin
        pending_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_biriscv_mul_issue_ctrl.sv
// Self-checking bench: closed-form event-time reference model per MUL transaction,
// with the bench acting as a multiplier of configurable latency.
module tb_biriscv_mul_issue_ctrl;

  localparam int TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic [31:0] issue_opcode_i = '0;
  logic [31:0] issue_pc_i = '0;
  logic [4:0]  issue_rd_idx_i = '0, issue_ra_idx_i = '0, issue_rb_idx_i = '0;
  logic [31:0] issue_ra_operand_i = '0, issue_rb_operand_i = '0;
  logic        issue_accept_o, illegal_o, busy_o, pending_valid_o;
  logic [4:0]  pending_rd_o;
  logic        flush_i = 1'b0;
  logic        mul_opcode_valid_o;
  logic [31:0] mul_opcode_opcode_o, mul_opcode_pc_o;
  logic [4:0]  mul_opcode_rd_idx_o, mul_opcode_ra_idx_o, mul_opcode_rb_idx_o;
  logic [31:0] mul_opcode_ra_operand_o, mul_opcode_rb_operand_o;
  logic        mul_wb_valid_i = 1'b0;
  logic [31:0] mul_wb_value_i = '0;
  logic [4:0]  mul_wb_rd_idx_i = '0;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_data_o;
  logic        error_o;

  int n_cmp = 0;
  int n_err = 0;

  biriscv_mul_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_opcode_i(issue_opcode_i), .issue_pc_i(issue_pc_i),
    .issue_rd_idx_i(issue_rd_idx_i), .issue_ra_idx_i(issue_ra_idx_i), .issue_rb_idx_i(issue_rb_idx_i),
    .issue_ra_operand_i(issue_ra_operand_i), .issue_rb_operand_i(issue_rb_operand_i),
    .issue_accept_o(issue_accept_o), .illegal_o(illegal_o), .busy_o(busy_o),
    .pending_valid_o(pending_valid_o), .pending_rd_o(pending_rd_o), .flush_i(flush_i),
    .mul_opcode_valid_o(mul_opcode_valid_o), .mul_opcode_opcode_o(mul_opcode_opcode_o),
    .mul_opcode_pc_o(mul_opcode_pc_o), .mul_opcode_rd_idx_o(mul_opcode_rd_idx_o),
    .mul_opcode_ra_idx_o(mul_opcode_ra_idx_o), .mul_opcode_rb_idx_o(mul_opcode_rb_idx_o),
    .mul_opcode_ra_operand_o(mul_opcode_ra_operand_o), .mul_opcode_rb_operand_o(mul_opcode_rb_operand_o),
    .mul_wb_valid_i(mul_wb_valid_i), .mul_wb_value_i(mul_wb_value_i), .mul_wb_rd_idx_i(mul_wb_rd_idx_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_idx_o(rf_wr_idx_o), .rf_wr_data_o(rf_wr_data_o),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    return {f7, rb, ra, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [190:0] outs();
    return {mul_opcode_valid_o, mul_opcode_opcode_o, mul_opcode_pc_o, mul_opcode_rd_idx_o,
            mul_opcode_ra_idx_o, mul_opcode_rb_idx_o, mul_opcode_ra_operand_o, mul_opcode_rb_operand_o,
            rf_wr_en_o, rf_wr_idx_o, rf_wr_data_o, busy_o, pending_valid_o, pending_rd_o,
            illegal_o, error_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL reset_outs: got %h want 0", outs());
    end
    n_cmp++;
    if (issue_accept_o !== 1'b0) begin
      n_err++; $display("FAIL reset_accept: got %b want 0", issue_accept_o);
    end
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL post_reset_outs: got %h want 0", outs());
    end
  endtask

  // One MUL transaction. Cycle k=0 is the accept cycle; the bench returns the
  // writeback in cycle 1+lat. Expected timeline derived directly from the rules:
  // dispatch at k=1, WAIT from k=2, abort after TMO wait cycles (k=TMO+2),
  // otherwise IDLE one cycle after the writeback.
  task automatic run_mul(input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input int lat, input int flush_k, input logic [4:0] wb_rd,
                         input bit spur, input string tag);
    int   k_wb, end_k, clr_k;
    bit   timed_out, flushed, exp_wr, exp_err;
    logic [31:0] instr, prod;
    instr     = enc(3'b000, 7'b0000001, rd, ra, rb);
    prod      = a * b;
    k_wb      = 1 + lat;
    timed_out = (k_wb > TMO + 1);
    end_k     = timed_out ? TMO + 2 : k_wb + 1;
    flushed   = (flush_k >= 1) && (flush_k < k_wb) && (flush_k < end_k);
    clr_k     = flushed ? flush_k + 1 : end_k;
    exp_wr    = !timed_out && !flushed && (wb_rd == rd) && (rd != 5'd0);
    exp_err   = timed_out || (!flushed && (wb_rd != rd));

    issue_valid_i = 1'b1; issue_opcode_i = instr; issue_pc_i = pc;
    issue_rd_idx_i = rd; issue_ra_idx_i = ra; issue_rb_idx_i = rb;
    issue_ra_operand_i = a; issue_rb_operand_i = b;
    flush_i = 1'b0; mul_wb_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (issue_accept_o !== 1'b1) begin
      n_err++; $display("FAIL %s accept: got %b want 1", tag, issue_accept_o);
    end

    for (int k = 1; k <= end_k; k++) begin
      tick();
      n_cmp++;
      if (mul_opcode_valid_o !== (k == 1)) begin
        n_err++; $display("FAIL %s opvalid k=%0d: got %b want %b", tag, k, mul_opcode_valid_o, (k == 1));
      end
      n_cmp++;
      if (busy_o !== (k < end_k)) begin
        n_err++; $display("FAIL %s busy k=%0d: got %b want %b", tag, k, busy_o, (k < end_k));
      end
      n_cmp++;
      if (pending_valid_o !== (k < clr_k)) begin
        n_err++; $display("FAIL %s pending k=%0d: got %b want %b", tag, k, pending_valid_o, (k < clr_k));
      end
      if (k < clr_k) begin
        n_cmp++;
        if (pending_rd_o !== rd) begin
          n_err++; $display("FAIL %s pending_rd k=%0d: got %0d want %0d", tag, k, pending_rd_o, rd);
        end
      end
      n_cmp++;
      if (rf_wr_en_o !== (k == end_k && exp_wr)) begin
        n_err++; $display("FAIL %s rf_wr_en k=%0d: got %b want %b", tag, k, rf_wr_en_o, (k == end_k && exp_wr));
      end
      if (k == end_k && exp_wr) begin
        n_cmp++;
        if ({rf_wr_idx_o, rf_wr_data_o} !== {rd, prod}) begin
          n_err++; $display("FAIL %s rf_wr: got x%0d=%h want x%0d=%h", tag, rf_wr_idx_o, rf_wr_data_o, rd, prod);
        end
      end
      n_cmp++;
      if (error_o !== (k == end_k && exp_err)) begin
        n_err++; $display("FAIL %s error k=%0d: got %b want %b", tag, k, error_o, (k == end_k && exp_err));
      end
      n_cmp++;
      if (illegal_o !== 1'b0) begin
        n_err++; $display("FAIL %s illegal k=%0d: got %b want 0", tag, k, illegal_o);
      end
      if (k < end_k) begin
        n_cmp++;
        if ({mul_opcode_opcode_o, mul_opcode_pc_o, mul_opcode_rd_idx_o, mul_opcode_ra_idx_o,
             mul_opcode_rb_idx_o, mul_opcode_ra_operand_o, mul_opcode_rb_operand_o}
            !== {instr, pc, rd, ra, rb, a, b}) begin
          n_err++; $display("FAIL %s opfields k=%0d: got %h/%h/%h/%h want %h/%h/%h/%h", tag, k,
                            mul_opcode_opcode_o, mul_opcode_pc_o, mul_opcode_ra_operand_o,
                            mul_opcode_rb_operand_o, instr, pc, a, b);
        end
      end

      if (k == end_k) begin
        issue_valid_i = 1'b0; flush_i = 1'b0; mul_wb_valid_i = 1'b0;
      end else begin
        // Offer another MUL while busy: it must not be taken.
        issue_valid_i = 1'($urandom_range(0, 1));
        issue_opcode_i = enc(3'b000, 7'b0000001, 5'($urandom), 5'($urandom), 5'($urandom));
        issue_pc_i = $urandom; issue_rd_idx_i = 5'($urandom);
        issue_ra_operand_i = $urandom; issue_rb_operand_i = $urandom;
        flush_i = (k == flush_k);
        if (k == k_wb) begin
          mul_wb_valid_i = 1'b1; mul_wb_value_i = prod; mul_wb_rd_idx_i = wb_rd;
        end else if (spur && k == 1) begin
          mul_wb_valid_i = 1'b1; mul_wb_value_i = $urandom; mul_wb_rd_idx_i = rd;
        end else begin
          mul_wb_valid_i = 1'b0; mul_wb_value_i = $urandom; mul_wb_rd_idx_i = 5'($urandom);
        end
        #1;
        n_cmp++;
        if (issue_accept_o !== 1'b0) begin
          n_err++; $display("FAIL %s accept_busy k=%0d: got %b want 0", tag, k, issue_accept_o);
        end
      end
    end
  endtask

  task automatic test_basic();
    run_mul(5'd5, 5'd1, 5'd2, 32'h0001_2345, 32'h0000_6789, 32'h8000_0100, 5, 0, 5'd5, 1'b0, "basic");
    run_mul(5'd0, 5'd3, 5'd4, 32'd3, 32'd4, 32'h8000_0104, 5, 0, 5'd0, 1'b0, "rd_zero");
  endtask

  task automatic test_illegal();
    for (int f3 = 1; f3 <= 3; f3++) begin
      issue_valid_i = 1'b1; issue_opcode_i = enc(3'(f3), 7'b0000001, 5'd6, 5'd1, 5'd2);
      #1;
      n_cmp++;
      if (issue_accept_o !== 1'b0) begin
        n_err++; $display("FAIL illegal_accept f3=%0d: got %b want 0", f3, issue_accept_o);
      end
      tick();
      issue_valid_i = 1'b0;
      n_cmp++;
      if ({illegal_o, mul_opcode_valid_o, busy_o} !== 3'b100) begin
        n_err++; $display("FAIL illegal_pulse f3=%0d: got %b want 100", f3, {illegal_o, mul_opcode_valid_o, busy_o});
      end
      tick();
      n_cmp++;
      if ({illegal_o, mul_opcode_valid_o, busy_o} !== 3'b000) begin
        n_err++; $display("FAIL illegal_after f3=%0d: got %b want 000", f3, {illegal_o, mul_opcode_valid_o, busy_o});
      end
    end
    // Flushed unsupported, and foreign instructions (ADD, DIV, OP-IMM): silent.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] insn;
      insn = (i == 2) ? enc(3'b100, 7'b0000001, 5'd6, 5'd1, 5'd2)
                      : enc((i == 0) ? 3'b011 : 3'b000, (i == 1) ? 7'b0000000 : 7'b0000001, 5'd6, 5'd1, 5'd2);
      if (i == 3) insn[6:0] = 7'b0010011;
      issue_valid_i = 1'b1; issue_opcode_i = insn; flush_i = (i == 0);
      #1;
      n_cmp++;
      if (issue_accept_o !== 1'b0) begin
        n_err++; $display("FAIL foreign_accept i=%0d: got %b want 0", i, issue_accept_o);
      end
      tick();
      issue_valid_i = 1'b0; flush_i = 1'b0;
      n_cmp++;
      if ({illegal_o, busy_o} !== 2'b00) begin
        n_err++; $display("FAIL foreign_quiet i=%0d: got %b want 00", i, {illegal_o, busy_o});
      end
    end
  endtask

  task automatic test_spurious_wb();
    mul_wb_valid_i = 1'b1; mul_wb_rd_idx_i = 5'd5; mul_wb_value_i = 32'hDEAD_BEEF;
    tick();
    mul_wb_valid_i = 1'b0;
    n_cmp++;
    if ({rf_wr_en_o, error_o, busy_o} !== 3'b000) begin
      n_err++; $display("FAIL idle_wb: got %b want 000", {rf_wr_en_o, error_o, busy_o});
    end
    run_mul(5'd8, 5'd9, 5'd10, 32'h0000_0011, 32'h0000_0022, 32'h100, 4, 0, 5'd8, 1'b1, "dispatch_wb");
  endtask

  task automatic test_flush_back_to_back();
    run_mul(5'd6, 5'd1, 5'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h200, 5, 3, 5'd6, 1'b0, "flush_wait");
    run_mul(5'd7, 5'd3, 5'd4, 32'hFFFF_FFFF, 32'h0000_0002, 32'h204, 5, 0, 5'd7, 1'b0, "after_flush");
    run_mul(5'd11, 5'd3, 5'd4, 32'h0000_1000, 32'h0000_1000, 32'h208, 6, 1, 5'd11, 1'b0, "flush_dispatch");
    run_mul(5'd12, 5'd3, 5'd4, 32'h0000_0007, 32'h0000_0009, 32'h20C, 5, 6, 5'd12, 1'b0, "wb_and_flush");
  endtask

  task automatic test_errors();
    run_mul(5'd13, 5'd1, 5'd2, 32'h5, 32'h6, 32'h300, 100, 0, 5'd13, 1'b0, "timeout");
    run_mul(5'd14, 5'd1, 5'd2, 32'h5, 32'h6, 32'h304, 16, 0, 5'd14, 1'b0, "last_cycle_wb");
    run_mul(5'd9, 5'd1, 5'd2, 32'h5, 32'h6, 32'h308, 5, 0, 5'd7, 1'b0, "rd_mismatch");
    run_mul(5'd15, 5'd1, 5'd2, 32'h5, 32'h6, 32'h30C, 100, 4, 5'd15, 1'b0, "drain_timeout");
  endtask

  task automatic test_reset_mid();
    issue_valid_i = 1'b1; issue_opcode_i = enc(3'b000, 7'b0000001, 5'd12, 5'd1, 5'd2);
    issue_rd_idx_i = 5'd12; issue_ra_operand_i = 32'h77; issue_rb_operand_i = 32'h88;
    #1;
    n_cmp++;
    if (issue_accept_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_accept: got %b want 1", issue_accept_o);
    end
    tick();
    issue_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    n_cmp++;
    if (outs() !== '0) begin
      n_err++; $display("FAIL rstmid_outs: got %h want 0", outs());
    end
    rst_i = 1'b0;
    mul_wb_valid_i = 1'b1; mul_wb_rd_idx_i = 5'd12; mul_wb_value_i = 32'h77 * 32'h88;
    tick();
    mul_wb_valid_i = 1'b0;
    n_cmp++;
    if ({rf_wr_en_o, busy_o, pending_valid_o} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_nowrite: got %b want 000", {rf_wr_en_o, busy_o, pending_valid_o});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [4:0] rd, wb_rd;
      int lat, fk;
      rd    = 5'($urandom);
      lat   = $urandom_range(1, 20);
      fk    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat + 1) : 0;
      wb_rd = ($urandom_range(0, 5) == 0) ? (rd ^ 5'($urandom_range(1, 31))) : rd;
      run_mul(rd, 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, lat, fk, wb_rd,
              1'($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_spurious_wb();
    test_flush_back_to_back();
    test_errors();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
